alu_mdu_seq: RTL and testbench



---
 rtl/alu_mdu_seq_pkg.sv | 48 ++++
 rtl/alu_mdu_seq_if.sv | 30 +++
 rtl/alu_mdu_seq_md_iter.sv | 136 +++++++++++++
 rtl/alu_mdu_seq.sv | 117 +++++++++++
 tb/tb_alu_mdu_seq.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_mdu_seq_pkg.sv
// alu_mdu_seq_pkg: shared definitions for the execute-stage ALU/MDU.
//   - ALUSel codes for the single-cycle ALU path
//   - md_op_e: RV32M funct3 encoding for the iterative path
//   - state_e: handshake FSM states
//   - helpers that build the divide-by-zero and signed-overflow results
//     for any XLEN up to 64
package alu_mdu_seq_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_B    = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Quotient of a divide by zero: all ones in the low xlen bits.
  function automatic logic [63:0] div0_quot(input int xlen);
    return {64{1'b1}} >> (64 - xlen);
  endfunction

  // Quotient of most-negative / -1: the most negative value itself.
  function automatic logic [63:0] ovf_quot(input int xlen);
    return 64'd1 << (xlen - 1);
  endfunction

endpackage

// File: rtl/alu_mdu_seq_if.sv
// alu_mdu_seq_if: issue/result bundle between the pipeline and alu_mdu_seq.
//   master (pipeline): flush, in_valid, op1, op2, alu_sel, md_en, md_op,
//                      out_ready  ->  in_ready, out_valid, res, busy
//   slave  (unit)    : the mirror image.
interface alu_mdu_seq_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [3:0]      alu_sel;
  logic            md_en;
  logic [2:0]      md_op;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] res;
  logic            busy;

  modport master (
    output flush, in_valid, op1, op2, alu_sel, md_en, md_op, out_ready,
    input  in_ready, out_valid, res, busy
  );

  modport slave (
    input  flush, in_valid, op1, op2, alu_sel, md_en, md_op, out_ready,
    output in_ready, out_valid, res, busy
  );
endinterface

// File: rtl/alu_mdu_seq_md_iter.sv
// md_iter: iterative RV32M multiply/divide datapath.
//   clk, rst_n   clock, synchronous active-low reset
//   flush        abandon the operation in flight
//   start        load operands and begin (one-cycle strobe)
//   op, op1, op2 operation and operands, sampled on start
//   done         high for the single cycle whose edge retires the last step
//   result       final value, valid while done is high
// Multiply retires MUL_BITS_PER_CYCLE multiplier bits per step into a
// {hi,lo} accumulator; divide is restoring, one quotient bit per step,
// reusing hi as partial remainder and lo as dividend/quotient. Operands are
// made non-negative at start and the sign is applied to the final-step
// value combinationally, so no extra cycle is spent on it.
module md_iter
  import alu_mdu_seq_pkg::*;
#(
  parameter int XLEN               = 32,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  md_op_e          op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int K     = MUL_BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN / K - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  DIV0_Q   = XLEN'(div0_quot(XLEN));
  localparam logic [XLEN-1:0]  OVF_Q    = XLEN'(ovf_quot(XLEN));

  logic                   active;
  logic [CNT_W-1:0]       cnt;
  md_op_e                 op_q;
  logic                   neg_q;
  logic                   rneg_q;
  logic                   div0_q;
  logic                   ovf_q;
  logic [XLEN-1:0]        op1_q;
  logic [XLEN-1:0]        hi;
  logic [XLEN-1:0]        lo;
  logic [XLEN-1:0]        mcand;

  logic                   a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]        a_mag, b_mag;
  logic signed [XLEN-1:0] a_s, b_s;

  logic [XLEN+K-1:0]      msum;
  logic [XLEN-1:0]        mhi, mlo;
  logic [XLEN:0]          dshift, ddiff;
  logic                   dge;
  logic [XLEN-1:0]        dhi, dlo;
  logic [2*XLEN-1:0]      prod, prod_fix;
  logic [XLEN-1:0]        quot, rem;

  // Operand conditioning at start: magnitudes and result signs.
  always_comb begin
    a_s      = $signed(op1);
    b_s      = $signed(op2);
    a_signed = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    b_signed = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    a_neg    = a_signed && (a_s < 0);
    b_neg    = b_signed && (b_s < 0);
    a_mag    = a_neg ? -op1 : op1;
    b_mag    = b_neg ? -op2 : op2;
  end

  // One step of each algorithm, computed from the current registers.
  always_comb begin
    msum   = {{K{1'b0}}, hi} + (XLEN+K)'(mcand) * (XLEN+K)'(lo[K-1:0]);
    mhi    = msum[XLEN+K-1:K];
    mlo    = {msum[K-1:0], lo[XLEN-1:K]};
    dshift = {hi, lo[XLEN-1]};
    ddiff  = dshift - {1'b0, mcand};
    dge    = ~ddiff[XLEN];
    dhi    = dge ? ddiff[XLEN-1:0] : dshift[XLEN-1:0];
    dlo    = {lo[XLEN-2:0], dge};
  end

  // Final-step value with sign fix-up and the two architectural corners.
  always_comb begin
    prod     = {mhi, mlo};
    prod_fix = neg_q ? -prod : prod;
    quot     = neg_q ? -dlo : dlo;
    rem      = rneg_q ? -dhi : dhi;
    if (div0_q) begin
      quot = DIV0_Q;
      rem  = op1_q;
    end else if (ovf_q) begin
      quot = OVF_Q;
      rem  = '0;
    end
    if (op_q[2])
      result = op_q[1] ? rem : quot;
    else if (op_q == MD_MUL)
      result = prod_fix[XLEN-1:0];
    else
      result = prod_fix[2*XLEN-1:XLEN];
  end

  assign done = active && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n || flush)
      active <= 1'b0;
    else if (start)
      active <= 1'b1;
    else if (done)
      active <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (start) begin
      cnt    <= op[2] ? DIV_LAST : MUL_LAST;
      op_q   <= op;
      neg_q  <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      div0_q <= op[2] && (op2 == '0);
      ovf_q  <= a_signed && b_signed && op[2] && (op1 == OVF_Q) && (op2 == DIV0_Q);
      op1_q  <= op1;
      hi     <= '0;
      lo     <= a_mag;
      mcand  <= b_mag;
    end else if (active) begin
      cnt <= cnt - 1'b1;
      hi  <= op_q[2] ? dhi : mhi;
      lo  <= op_q[2] ? dlo : mlo;
    end
  end

endmodule

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: execute-stage ALU with an iterative RV32M multiply/divide unit.
//   clk, rst_n  clock, synchronous active-low reset
//   bus (slave) issue side: flush, in_valid/in_ready, op1, op2, alu_sel,
//               md_en, md_op; result side: out_valid/out_ready, res; busy
// ALU ops complete in one cycle, M-extension ops in XLEN/MUL_BITS_PER_CYCLE+1
// (multiply) or XLEN+1 (divide) cycles. A held result in DONE can be handed
// off to a new issue in the same cycle it is consumed.
module alu_mdu_seq
  import alu_mdu_seq_pkg::*;
#(
  parameter int XLEN               = 32,
  parameter int MUL_BITS_PER_CYCLE = 1,
  parameter int SHAMT_W            = $clog2(XLEN)
) (
  input  logic clk,
  input  logic rst_n,
  alu_mdu_seq_if.slave bus
);

  state_e          state, state_nxt;
  logic            in_ready, fire, take, md_start, md_done;
  logic [XLEN-1:0] md_result;
  logic [XLEN-1:0] res_p1;

  function automatic logic [XLEN-1:0] alu_calc(input logic [3:0] sel,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] a_s, b_s;
    logic [SHAMT_W-1:0]     sh;
    logic                   lt;
    a_s = $signed(a);
    b_s = $signed(b);
    sh  = b[SHAMT_W-1:0];
    case (sel)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_XOR:  return a ^ b;
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return a_s >>> sh;
      ALU_B:    return b;
      ALU_SLT: begin
        lt = a_s < b_s;
        return {{(XLEN-1){1'b0}}, lt};
      end
      ALU_SLTU: begin
        lt = a < b;
        return {{(XLEN-1){1'b0}}, lt};
      end
      default:  return {(XLEN/4){4'h1}};
    endcase
  endfunction

  assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
  assign fire     = bus.in_valid && in_ready;
  assign take     = fire && !bus.flush;

  always_comb begin
    state_nxt = state;
    md_start  = take && bus.md_en;
    if (bus.flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (fire) state_nxt = bus.md_en ? ST_CALC : ST_DONE;
        ST_CALC: if (md_done) state_nxt = ST_DONE;
        ST_DONE: begin
          if (fire)
            state_nxt = bus.md_en ? ST_CALC : ST_DONE;
          else if (bus.out_ready)
            state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Result stage: ALU result on issue, M-extension result on its last step.
  always_ff @(posedge clk) begin
    if (!rst_n)
      res_p1 <= '0;
    else if (take && !bus.md_en)
      res_p1 <= alu_calc(bus.alu_sel, bus.op1, bus.op2);
    else if ((state == ST_CALC) && md_done && !bus.flush)
      res_p1 <= md_result;
  end

  md_iter #(
    .XLEN              (XLEN),
    .MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)
  ) u_md_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.flush),
    .start (md_start),
    .op    (md_op_e'(bus.md_op)),
    .op1   (bus.op1),
    .op2   (bus.op2),
    .done  (md_done),
    .result(md_result)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state == ST_CALC);
  assign bus.res       = res_p1;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb_alu_mdu_seq: directed bench for alu_mdu_seq at XLEN=32/1 bit per cycle
// plus a second instance at XLEN=64/4 bits per cycle.
module tb_alu_mdu_seq;
  import alu_mdu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_mdu_seq_if #(.XLEN(32)) bus ();
  alu_mdu_seq_if #(.XLEN(64)) bus64 ();

  alu_mdu_seq #(.XLEN(32), .MUL_BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  alu_mdu_seq #(.XLEN(64), .MUL_BITS_PER_CYCLE(4)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .bus(bus64)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on the 32-bit bus, scramble operands after fire, and wait
  // (bounded) for out_valid. lat counts the fire edge as 1.
  task automatic issue_wait(input logic md, input logic [3:0] sel, input logic [2:0] mop,
                            input logic [31:0] a, input logic [31:0] b,
                            output int lat, output bit stall_ok);
    bus.in_valid = 1'b1; bus.md_en = md; bus.alu_sel = sel; bus.md_op = mop;
    bus.op1 = a; bus.op2 = b;
    step();
    bus.in_valid = 1'b0; bus.op1 = 32'hDEADBEEF; bus.op2 = 32'h13579BDF;
    lat = 1; stall_ok = 1'b1;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) stall_ok = 1'b0;
      step();
      lat++;
    end
  endtask

  task automatic issue_wait64(input logic md, input logic [3:0] sel, input logic [2:0] mop,
                              input logic [63:0] a, input logic [63:0] b,
                              output int lat);
    bus64.in_valid = 1'b1; bus64.md_en = md; bus64.alu_sel = sel; bus64.md_op = mop;
    bus64.op1 = a; bus64.op2 = b;
    step();
    bus64.in_valid = 1'b0; bus64.op1 = 64'hDEAD_BEEF_0BAD_F00D; bus64.op2 = 64'h5;
    lat = 1;
    while (bus64.out_valid !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.flush = 0; bus.in_valid = 0; bus.op1 = 0; bus.op2 = 0; bus.alu_sel = 0;
    bus.md_en = 0; bus.md_op = 0; bus.out_ready = 1;
    bus64.flush = 0; bus64.in_valid = 0; bus64.op1 = 0; bus64.op2 = 0; bus64.alu_sel = 0;
    bus64.md_en = 0; bus64.md_op = 0; bus64.out_ready = 1;
    step(); step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.res !== 32'h0) begin errors++; $display("FAIL reset res: got %h expected 00000000", bus.res); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", bus.in_ready); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu_stream();
    logic [3:0]  sel [13];
    logic [31:0] a [13];
    logic [31:0] b [13];
    logic [31:0] e [13];
    sel = '{ALU_ADD, ALU_SUB, ALU_SRA, ALU_SLTU, ALU_SLT, ALU_SLTU, ALU_SLL,
            ALU_SRL, ALU_XOR, ALU_OR, ALU_AND, ALU_B, 4'hF};
    a   = '{32'd5, 32'd3, 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,
            32'h80000000, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h1234, 32'h0};
    b   = '{32'd7, 32'd5, 32'd4, 32'd2, 32'd1, 32'd1, 32'h21,
            32'd4, 32'hFF00FF00, 32'h0F0F0000, 32'hFF00FF00, 32'h5678, 32'h0};
    e   = '{32'd12, 32'hFFFFFFFE, 32'hF8000000, 32'd1, 32'd1, 32'd0, 32'd2,
            32'h08000000, 32'h0FF00FF0, 32'hFFFFF0F0, 32'hF000F000, 32'h5678, 32'h11111111};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      bus.in_valid = 1'b1; bus.md_en = 1'b0; bus.alu_sel = sel[i];
      bus.op1 = a[i]; bus.op2 = b[i];
      step();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL alu[%0d] out_valid: got %b expected 1", i, bus.out_valid); end
      checks++; if (bus.res !== e[i]) begin errors++; $display("FAIL alu[%0d] res: got %h expected %h", i, bus.res, e[i]); end
    end
    bus.in_valid = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL alu drain out_valid: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_mul();
    logic [2:0]  op [8];
    logic [31:0] a [8];
    logic [31:0] b [8];
    logic [31:0] e [8];
    int lat; bit ok;
    op = '{MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_MULH, MD_MULHU, MD_MULHSU, MD_MUL};
    a  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'h80000000, 32'h80000000, 32'h80000000, 32'h12345678};
    b  = '{32'd2, 32'd2, 32'd2, 32'd2, 32'h80000000, 32'h80000000, 32'h80000000, 32'h10};
    e  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,
           32'h40000000, 32'h40000000, 32'hC0000000, 32'h23456780};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue_wait(1'b1, 4'h0, op[i], a[i], b[i], lat, ok);
      checks++; if (bus.res !== e[i]) begin errors++; $display("FAIL mul[%0d] res: got %h expected %h", i, bus.res, e[i]); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL mul[%0d] latency: got %0d expected 33", i, lat); end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mul[%0d] busy/in_ready during CALC: got %b expected 1", i, ok); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  op [11];
    logic [31:0] a [11];
    logic [31:0] b [11];
    logic [31:0] e [11];
    int lat; bit ok;
    op = '{MD_DIV, MD_REMU, MD_DIV, MD_REM, MD_DIV, MD_REM, MD_DIVU, MD_REMU,
           MD_REM, MD_DIV, MD_DIVU};
    a  = '{32'd7, 32'd7, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9,
           32'd100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF};
    b  = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
           32'd7, 32'd7, 32'd0, 32'd0, 32'd1};
    e  = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd0, 32'hFFFFFFFD, 32'hFFFFFFFF,
           32'd14, 32'd2, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFFF};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      issue_wait(1'b1, 4'h0, op[i], a[i], b[i], lat, ok);
      checks++; if (bus.res !== e[i]) begin errors++; $display("FAIL div[%0d] res: got %h expected %h", i, bus.res, e[i]); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL div[%0d] latency: got %0d expected 33", i, lat); end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL div[%0d] busy/in_ready during CALC: got %b expected 1", i, ok); end
    end
  endtask

  task automatic test_backpressure();
    int lat, xfers; bit ok;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    issue_wait(1'b1, 4'h0, MD_DIVU, 32'd100, 32'd7, lat, ok);
    checks++; if (lat !== 33) begin errors++; $display("FAIL bp latency: got %0d expected 33", lat); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp[%0d] out_valid: got %b expected 1", i, bus.out_valid); end
      checks++; if (bus.res !== 32'd14) begin errors++; $display("FAIL bp[%0d] res: got %h expected 0000000e", i, bus.res); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp[%0d] in_ready: got %b expected 0", i, bus.in_ready); end
      step();
    end
    bus.out_ready = 1'b1;
    xfers = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) xfers++;
      step();
    end
    checks++; if (xfers !== 1) begin errors++; $display("FAIL bp transfers: got %0d expected 1", xfers); end
  endtask

  task automatic test_flush();
    int lat, seen; bit ok;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.md_en = 1'b1; bus.md_op = MD_DIV; bus.op1 = 32'd100; bus.op2 = 32'd7;
    step();
    bus.in_valid = 1'b0;
    step(); step(); step(); step();
    bus.flush = 1'b1;
    bus.in_valid = 1'b1; bus.md_en = 1'b0; bus.alu_sel = ALU_ADD; bus.op1 = 32'd1; bus.op2 = 32'd1;
    step();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush busy: got %b expected 0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.res !== 32'd14) begin errors++; $display("FAIL flush res kept: got %h expected 0000000e", bus.res); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid !== 1'b0) seen++;
      step();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush late out_valid cycles: got %0d expected 0", seen); end
    issue_wait(1'b0, ALU_ADD, 3'd0, 32'd20, 32'd22, lat, ok);
    checks++; if (lat !== 1) begin errors++; $display("FAIL post-flush add latency: got %0d expected 1", lat); end
    checks++; if (bus.res !== 32'd42) begin errors++; $display("FAIL post-flush add res: got %h expected 0000002a", bus.res); end
    step();
    bus.flush = 1'b1;
    bus.in_valid = 1'b1; bus.md_en = 1'b0; bus.alu_sel = ALU_ADD; bus.op1 = 32'd1; bus.op2 = 32'd1;
    step();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush idle issue out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.res !== 32'd42) begin errors++; $display("FAIL flush idle issue res: got %h expected 0000002a", bus.res); end
    bus.out_ready = 1'b0;
    issue_wait(1'b0, ALU_ADD, 3'd0, 32'd2, 32'd3, lat, ok);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush held result out_valid: got %b expected 0", bus.out_valid); end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.md_en = 1'b1; bus.md_op = MD_MUL; bus.op1 = 32'd3; bus.op2 = 32'd5;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.res !== 32'h0) begin errors++; $display("FAIL midreset res: got %h expected 00000000", bus.res); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset busy: got %b expected 0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midreset in_ready: got %b expected 1", bus.in_ready); end
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid !== 1'b0) seen++;
      step();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset late out_valid cycles: got %0d expected 0", seen); end
  endtask

  task automatic test_param_sweep();
    logic        md [8];
    logic [3:0]  sel [8];
    logic [2:0]  op [8];
    logic [63:0] a [8];
    logic [63:0] b [8];
    logic [63:0] e [8];
    int          l [8];
    int          lat;
    md  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    sel = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, ALU_SRA, 4'hC};
    op  = '{MD_MULHU, MD_MUL, MD_MULH, MD_MUL, MD_DIV, MD_REM, MD_MUL, MD_MUL};
    a   = '{64'hFFFFFFFF_FFFFFFFF, 64'h00000001_00000001, 64'hFFFFFFFF_FFFFFFFD,
            64'hFFFFFFFF_FFFFFFFD, 64'hFFFFFFFF_FFFFFF9C, 64'hFFFFFFFF_FFFFFF9C,
            64'h80000000_00000000, 64'h0};
    b   = '{64'd2, 64'h00000001_00000001, 64'd5, 64'd5, 64'd7, 64'd7, 64'h7F, 64'h0};
    e   = '{64'd1, 64'h00000002_00000001, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFF1,
            64'hFFFFFFFF_FFFFFFF2, 64'hFFFFFFFF_FFFFFFFE, 64'hFFFFFFFF_FFFFFFFF,
            64'h11111111_11111111};
    l   = '{17, 17, 17, 17, 65, 65, 1, 1};
    bus64.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue_wait64(md[i], sel[i], op[i], a[i], b[i], lat);
      checks++; if (bus64.res !== e[i]) begin errors++; $display("FAIL x64[%0d] res: got %h expected %h", i, bus64.res, e[i]); end
      checks++; if (lat !== l[i]) begin errors++; $display("FAIL x64[%0d] latency: got %0d expected %0d", i, lat, l[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_alu_stream();
    test_mul();
    test_div();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
